// File: rtl/sound_register_file.sv
// sound_register_file
//   CPU-facing register block for the four sound channels. Decodes byte
//   accesses to FF10..FF3F, holds NR10..NR52 and the 16-byte wave RAM, and
//   stretches NRx4 trigger writes into per-channel reset pulses that are long
//   enough for the slow length/envelope/sweep/frequency clocks to sample.
//
// Ports
//   clk, reset        system clock, synchronous active-high reset
//   addr, data_in     CPU address / write data
//   mem_we, mem_re    one-cycle write / read strobes
//   data_out          registered read data (updated on mem_re)
//   sel               combinational decode of FF10..FF3F
//   ch_done[3:0]      per-channel length-expired level inputs
//   ch1..ch4_regs     packed control registers, lowest register in LSBs
//   ch3_samples       wave RAM, sample k at [4k+3:4k]
//   nr50, nr51        master volume / panning
//   ch_reset[3:0]     stretched per-channel reset pulses
//   sound_on          NR52 bit 7
module sound_register_file #(
  parameter int TRIG_CYCLES = 65536
) (
  input  logic         clk,
  input  logic         reset,
  input  logic [15:0]  addr,
  input  logic [7:0]   data_in,
  input  logic         mem_we,
  input  logic         mem_re,
  output logic [7:0]   data_out,
  output logic         sel,
  input  logic [3:0]   ch_done,
  output logic [39:0]  ch1_regs,
  output logic [31:0]  ch2_regs,
  output logic [39:0]  ch3_regs,
  output logic [31:0]  ch4_regs,
  output logic [127:0] ch3_samples,
  output logic [7:0]   nr50,
  output logic [7:0]   nr51,
  output logic [3:0]   ch_reset,
  output logic         sound_on
);

  localparam int CW = 17;
  localparam logic [CW-1:0] TRIG_LOAD = CW'(TRIG_CYCLES);
  localparam int RLO = 16;   // 0x10: NR10
  localparam int RHI = 37;   // 0x25: NR51

  // Register space indexed directly by addr[5:0]; 0x15 and 0x1F are never
  // written and so stay at their reset value of 0.
  logic [7:0]    regs_q [RLO:RHI];
  logic [7:0]    regs_d [RLO:RHI];
  logic [7:0]    wave_q [16];
  logic [7:0]    wave_d [16];
  logic [CW-1:0] cnt_q  [4];
  logic [CW-1:0] cnt_d  [4];
  logic [3:0]    chr_q, chr_d;
  logic [3:0]    status_q, status_d;
  logic          sound_on_q, sound_on_d;
  logic [7:0]    data_out_q, data_out_d;

  logic [5:0] off;
  logic       is_reg, is_nr52, is_wave, wr;
  logic [3:0] trig;
  logic [7:0] rd_val;

  function automatic logic [7:0] rd_mask(input logic [5:0] o);
    case (o)
      6'h10: rd_mask = 8'h80;
      6'h11: rd_mask = 8'h3F;
      6'h13: rd_mask = 8'hFF;
      6'h14: rd_mask = 8'hBF;
      6'h16: rd_mask = 8'h3F;
      6'h18: rd_mask = 8'hFF;
      6'h19: rd_mask = 8'hBF;
      6'h1A: rd_mask = 8'h7F;
      6'h1B: rd_mask = 8'hFF;
      6'h1C: rd_mask = 8'h9F;
      6'h1D: rd_mask = 8'hFF;
      6'h1E: rd_mask = 8'hBF;
      6'h20: rd_mask = 8'hFF;
      6'h23: rd_mask = 8'hBF;
      default: rd_mask = 8'h00;
    endcase
  endfunction

  // FF10..FF3F: high byte FF, bits [7:6]=00, bits [5:4] non-zero.
  assign off     = addr[5:0];
  assign sel     = (addr[15:8] == 8'hFF) && (addr[7:6] == 2'b00) && (addr[5:4] != 2'b00);
  assign is_reg  = sel && (off <= 6'h25) && (off != 6'h15) && (off != 6'h1F);
  assign is_nr52 = sel && (off == 6'h26);
  assign is_wave = sel && (off[5:4] == 2'b11);
  assign wr      = mem_we && sel;

  always_comb begin
    sound_on_d = sound_on_q;
    regs_d     = regs_q;
    wave_d     = wave_q;
    trig       = 4'b0000;
    status_d   = status_q;
    chr_d      = chr_q;
    cnt_d      = cnt_q;
    rd_val     = 8'hFF;
    data_out_d = data_out_q;

    if (wr && is_nr52)
      sound_on_d = data_in[7];

    // Register writes only land while powered; trigger bit is never stored.
    if (wr && is_reg && sound_on_q) begin
      regs_d[off] = data_in;
      case (off)
        6'h14: begin regs_d[off][7] = 1'b0; trig[0] = data_in[7]; end
        6'h19: begin regs_d[off][7] = 1'b0; trig[1] = data_in[7]; end
        6'h1E: begin regs_d[off][7] = 1'b0; trig[2] = data_in[7]; end
        6'h23: begin regs_d[off][7] = 1'b0; trig[3] = data_in[7]; end
        default: ;
      endcase
    end

    // Power-off clears NR10..NR51 on the same edge that sound_on falls.
    if (!sound_on_d)
      for (int i = RLO; i <= RHI; i++) regs_d[i] = 8'h00;

    if (wr && is_wave)
      wave_d[off[3:0]] = data_in;

    for (int n = 0; n < 4; n++) begin
      // Counters run regardless of power so a pulse still in flight at
      // power-on finishes its full length.
      if (trig[n])             cnt_d[n] = TRIG_LOAD;
      else if (cnt_q[n] != '0) cnt_d[n] = cnt_q[n] - 1'b1;

      // cnt_q > 1 keeps the pulse high for exactly TRIG_CYCLES edges.
      // Held high while off and on the power-on edge itself.
      if (!sound_on_d || !sound_on_q || trig[n]) chr_d[n] = 1'b1;
      else                                      chr_d[n] = (cnt_q[n] > CW'(1));

      if (!sound_on_d)    status_d[n] = 1'b0;
      else if (trig[n])   status_d[n] = 1'b1;
      else if (ch_done[n]) status_d[n] = 1'b0;
    end

    // Reads see pre-edge state, so same-cycle read+write returns the old value.
    if (is_reg)       rd_val = regs_q[off] | rd_mask(off);
    else if (is_nr52) rd_val = {sound_on_q, 3'b111, status_q};
    else if (is_wave) rd_val = wave_q[off[3:0]];

    if (mem_re) data_out_d = rd_val;
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      for (int i = RLO; i <= RHI; i++) regs_q[i] <= 8'h00;
      for (int i = 0; i < 16; i++) wave_q[i] <= 8'h00;
      for (int n = 0; n < 4; n++) cnt_q[n] <= '0;
      chr_q      <= 4'hF;
      status_q   <= 4'h0;
      sound_on_q <= 1'b0;
      data_out_q <= 8'h00;
    end else begin
      regs_q     <= regs_d;
      wave_q     <= wave_d;
      cnt_q      <= cnt_d;
      chr_q      <= chr_d;
      status_q   <= status_d;
      sound_on_q <= sound_on_d;
      data_out_q <= data_out_d;
    end
  end

  assign ch1_regs = {regs_q[20], regs_q[19], regs_q[18], regs_q[17], regs_q[16]};
  assign ch2_regs = {regs_q[25], regs_q[24], regs_q[23], regs_q[22]};
  assign ch3_regs = {regs_q[30], regs_q[29], regs_q[28], regs_q[27], regs_q[26]};
  assign ch4_regs = {regs_q[35], regs_q[34], regs_q[33], regs_q[32]};
  assign nr50     = regs_q[36];
  assign nr51     = regs_q[37];
  assign ch_reset = chr_q;
  assign sound_on = sound_on_q;
  assign data_out = data_out_q;

  // High nibble of each byte is the earlier sample.
  for (genvar b = 0; b < 16; b++) begin : g_wave
    assign ch3_samples[8*b+3 -: 4] = wave_q[b][7:4];
    assign ch3_samples[8*b+7 -: 4] = wave_q[b][3:0];
  end

endmodule

// File: tb/tb_sound_register_file.sv
module tb_sound_register_file;
  logic         clk = 1'b0;
  logic         reset;
  logic [15:0]  addr;
  logic [7:0]   data_in;
  logic         mem_we, mem_re;
  logic [7:0]   data_out;
  logic         sel;
  logic [3:0]   ch_done;
  logic [39:0]  ch1_regs;
  logic [31:0]  ch2_regs;
  logic [39:0]  ch3_regs;
  logic [31:0]  ch4_regs;
  logic [127:0] ch3_samples;
  logic [7:0]   nr50, nr51;
  logic [3:0]   ch_reset;
  logic         sound_on;

  int errs = 0;
  int checks = 0;
  int hcnt;

  sound_register_file #(.TRIG_CYCLES(8)) dut (
    .clk(clk), .reset(reset), .addr(addr), .data_in(data_in),
    .mem_we(mem_we), .mem_re(mem_re), .data_out(data_out), .sel(sel),
    .ch_done(ch_done), .ch1_regs(ch1_regs), .ch2_regs(ch2_regs),
    .ch3_regs(ch3_regs), .ch4_regs(ch4_regs), .ch3_samples(ch3_samples),
    .nr50(nr50), .nr51(nr51), .ch_reset(ch_reset), .sound_on(sound_on)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [127:0] obs, input logic [127:0] exp);
    checks++;
    assert (obs === exp) else begin
      errs++;
      $error("FAIL %s: got %0h expected %0h", tag, obs, exp);
    end
  endtask

  // All tasks start and end on a falling edge.
  task automatic wr(input logic [15:0] a, input logic [7:0] d);
    addr = a; data_in = d; mem_we = 1'b1;
    @(negedge clk);
    mem_we = 1'b0;
  endtask

  task automatic rd(input string tag, input logic [15:0] a, input logic [7:0] exp);
    addr = a; mem_re = 1'b1;
    @(negedge clk);
    mem_re = 1'b0;
    check(tag, 128'(data_out), 128'(exp));
  endtask

  initial begin
    reset = 1'b1; addr = 16'h0000; data_in = 8'h00;
    mem_we = 1'b0; mem_re = 1'b0; ch_done = 4'h0;
    @(negedge clk); @(negedge clk);
    reset = 1'b0;

    // Reset state
    check("rst_data_out", 128'(data_out), 128'h00);
    check("rst_ch_reset", 128'(ch_reset), 128'hF);
    check("rst_sound_on", 128'(sound_on), 128'h0);
    check("rst_ch1_regs", 128'(ch1_regs), 128'h0);
    check("rst_samples", ch3_samples, 128'h0);

    // Decode
    addr = 16'hFF10; #1 check("sel_ff10", 128'(sel), 128'h1);
    addr = 16'hFF3F; #1 check("sel_ff3f", 128'(sel), 128'h1);
    addr = 16'hFF0F; #1 check("sel_ff0f", 128'(sel), 128'h0);
    addr = 16'hFF40; #1 check("sel_ff40", 128'(sel), 128'h0);
    @(negedge clk);

    // Power-on: ch_reset held on the write edge, drops on the next
    wr(16'hFF26, 8'h80);
    check("pon_sound_on", 128'(sound_on), 128'h1);
    check("pon_hold", 128'(ch_reset), 128'hF);
    @(negedge clk);
    check("pon_ch_reset", 128'(ch_reset), 128'h0);
    rd("rd_nr52_on", 16'hFF26, 8'hF0);

    // Channel 1 trigger
    wr(16'hFF13, 8'h34);
    wr(16'hFF14, 8'hC5);
    check("ch1_nr14_nr13", 128'(ch1_regs[39:24]), 128'h4534);
    hcnt = 0;
    for (int i = 0; i < 30; i++) begin
      if (ch_reset[0]) hcnt++;
      @(negedge clk);
    end
    check("ch1_pulse_len", 128'(hcnt), 128'd8);
    rd("rd_nr14", 16'hFF14, 8'hFF);
    rd("rd_nr52_ch1", 16'hFF26, 8'hF1);

    // Channel 2 retrigger 3 cycles in, with ch_done[1] in the same cycle
    wr(16'hFF19, 8'h80);
    hcnt = 0;
    for (int i = 0; i < 30; i++) begin
      if (ch_reset[1]) hcnt++;
      if (i == 2) begin addr = 16'hFF19; data_in = 8'h80; mem_we = 1'b1; ch_done = 4'b0010; end
      if (i == 3) begin mem_we = 1'b0; ch_done = 4'b0000; end
      @(negedge clk);
    end
    check("ch2_retrig_len", 128'(hcnt), 128'd11);
    check("ch2_nr24_stored", 128'(ch2_regs[31:24]), 128'h00);
    rd("rd_nr52_ch12", 16'hFF26, 8'hF3);
    ch_done = 4'b0001;
    @(negedge clk);
    ch_done = 4'b0000;
    rd("rd_nr52_done1", 16'hFF26, 8'hF2);

    // Wave RAM packing
    wr(16'hFF30, 8'hA5);
    check("wave_s0", 128'(ch3_samples[3:0]), 128'hA);
    check("wave_s1", 128'(ch3_samples[7:4]), 128'h5);
    wr(16'hFF3F, 8'h12);
    check("wave_s30", 128'(ch3_samples[123:120]), 128'h1);
    check("wave_s31", 128'(ch3_samples[127:124]), 128'h2);
    rd("rd_ff30", 16'hFF30, 8'hA5);

    // Power-off
    wr(16'hFF24, 8'h77);
    wr(16'hFF12, 8'hF3);
    check("nr50_set", 128'(nr50), 128'h77);
    check("nr12_set", 128'(ch1_regs[23:16]), 128'hF3);
    wr(16'hFF26, 8'h00);
    check("poff_nr50", 128'(nr50), 128'h0);
    check("poff_ch1", 128'(ch1_regs), 128'h0);
    check("poff_ch_reset", 128'(ch_reset), 128'hF);
    wr(16'hFF24, 8'h55);
    check("poff_nr50_wr", 128'(nr50), 128'h0);
    wr(16'hFF31, 8'h3C);
    check("poff_wave_wr", 128'(ch3_samples[15:8]), 128'hC3);
    wr(16'hFF14, 8'h80);
    check("poff_trig_ch1", 128'(ch1_regs), 128'h0);
    rd("rd_nr52_off", 16'hFF26, 8'h70);

    // Power back on; masks and unmapped reads
    wr(16'hFF26, 8'h80);
    @(negedge clk);
    rd("rd_ff15", 16'hFF15, 8'hFF);
    rd("rd_ff2a", 16'hFF2A, 8'hFF);
    wr(16'hFF1C, 8'h60);
    rd("rd_nr32", 16'hFF1C, 8'hFF);
    wr(16'hFF10, 8'h00);
    rd("rd_nr10", 16'hFF10, 8'h80);
    wr(16'hFF12, 8'h5A);
    rd("rd_nr12", 16'hFF12, 8'h5A);

    // Same-cycle read and write returns the old value
    addr = 16'hFF25; data_in = 8'h11; mem_we = 1'b1; mem_re = 1'b1;
    @(negedge clk);
    mem_we = 1'b0; mem_re = 1'b0;
    check("rw_same_old", 128'(data_out), 128'h00);
    check("rw_same_nr51", 128'(nr51), 128'h11);
    rd("rd_nr51", 16'hFF25, 8'h11);

    // Reset mid-pulse clears counters
    wr(16'hFF23, 8'h80);
    check("ch4_trig", 128'(ch_reset), 128'h8);
    @(negedge clk);
    reset = 1'b1;
    @(negedge clk);
    reset = 1'b0;
    check("mid_rst_ch_reset", 128'(ch_reset), 128'hF);
    check("mid_rst_sound_on", 128'(sound_on), 128'h0);
    check("mid_rst_data_out", 128'(data_out), 128'h00);
    check("mid_rst_samples", ch3_samples, 128'h0);
    wr(16'hFF26, 8'h80);
    @(negedge clk);
    check("mid_rst_cnt_clear", 128'(ch_reset), 128'h0);

    $display("Result: errors=%0d of %0d checks", errs, checks);
    $finish;
  end
endmodule
